dcache_ctrl: RTL and testbench
==============================

Name: dcache_ctrl

Overview:
Direct-mapped, write-back, write-allocate data cache controller between the memory stage and a handshaked word-wide main memory.
- Provides the DCacheReq/DCacheHit and stall information that the processor-hierarchy bench counts.
- Blocking design: one outstanding request at a time; the requester stalls for the whole of a miss.

Parameters:
- INDEX_W, 5, index bits; number of lines = 2**INDEX_W.
- Fixed geometry: 4 words per line, 16-bit words, byte addresses.
- Address split: offset = Addr[2:1], index = Addr[2+INDEX_W:3], tag = remaining upper bits (8 bits at default).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-low.
- Addr  in  16  byte address of the request.
- DataIn  in  16  store data.
- Rd  in  1  load request.
- Wr  in  1  store request.
- DataOut  out  16  load data; valid when Done=1.
- Done  out  1  request completed this cycle.
- Stall  out  1  requester must hold its request.
- CacheHit  out  1  request completed without memory traffic.
- Err  out  1  illegal request.
- mem_req  out  1  memory transfer request.
- mem_we  out  1  1 = write, 0 = read.
- mem_addr  out  16  word-aligned memory address.
- mem_wdata  out  16  memory write data.
- mem_rdata  in  16  memory read data; valid with mem_ack.
- mem_ack  in  1  transfer completes this cycle.
- req_count  out  16  statistics counter (see Optional Feature).
- hit_count  out  16  statistics counter (see Optional Feature).

Behaviour:
- Reset (rst=0 at a clk edge):
  - All valid and dirty bits cleared; FSM goes to IDLE.
  - All outputs 0, counters 0.
  - Reset mid-miss abandons the memory transfer; mem_req=0 from the next cycle; dirty data is discarded.
- States: IDLE, WB, FILL, COMPLETE.
- IDLE accepts Rd|Wr. Lookup is combinational in the request cycle.
- Err: Addr[0]=1, or Rd&Wr both high.
  - Err=1 and Done=1 for that cycle.
  - No array or memory change; stays in IDLE.
- Hit (valid and tag match):
  - Done=1, CacheHit=1 in the same cycle.
  - Load: DataOut = array word.
  - Store: word written and dirty set at the closing edge.
  - Zero-cycle stall.
- Miss:
  - Stall=1 in the request cycle; Addr, DataIn, Rd and Wr are latched at that edge.
  - Next state: WB if the victim is valid and dirty, else FILL.
- WB: words k=0..3, one at a time.
  - Drive mem_req=1, mem_we=1, mem_addr={victim_tag,index,k,1'b0}, mem_wdata = line word k.
  - All memory outputs are held stable until mem_ack; k advances on ack.
  - After ack on word 3, go to FILL.
- FILL: words k=0..3.
  - Drive mem_req=1, mem_we=0, mem_addr={req_tag,index,k,1'b0}.
  - On mem_ack, mem_rdata is written to word k.
  - After word 3: tag written, valid=1, dirty=0; go to COMPLETE.
- COMPLETE:
  - Replays the latched request as a hit: Done=1, CacheHit=0, Stall=0.
  - A store merges its word and sets dirty.
  - Returns to IDLE; a new request is accepted in the next cycle.
- Stall=1 in the miss-request cycle and throughout WB and FILL; 0 otherwise.
- mem_req=0 in IDLE and COMPLETE.
- Inputs in non-IDLE states are ignored.
- mem_ack while mem_req=0 is ignored.
- Memory back-to-back acks are allowed: one word per cycle, so the minimum clean miss is 6 cycles from request to Done.

Optional Feature:
- DCACHE_STATS_EN defined:
  - req_count increments on each non-Err request accepted in IDLE.
  - hit_count increments on each hit in IDLE.
  - Both counters are 16-bit and saturate at 0xFFFF.
- DCACHE_STATS_EN undefined: both ports tied to 0 and no counter registers exist.

Decomposition:
- Package dcache_pkg holds:
  - state encoding (IDLE/WB/FILL/COMPLETE);
  - WORDS_PER_LINE=4 and OFFSET_W=2;
  - the tag-width derivation function.
- One sub-module, dcache_array:
  - tag/valid/dirty/data storage;
  - one combinational read port (index, offset);
  - one synchronous write port (word write, tag/valid/dirty update);
  - synchronous active-low clear of valid and dirty.

Test Plan:
1. After reset, memory word at 0x0010 = 0x1234; Rd 0x0010.
   - Stall; reads at 0x0010, 0x0012, 0x0014, 0x0016 (acks immediate).
   - Done with CacheHit=0 and DataOut=0x1234 exactly 6 cycles after the request.
2. Then Rd 0x0014.
   - Done=1, CacheHit=1 in the same cycle; no mem_req.
3. Wr 0x0012 = 0xBEEF (hit), then Rd 0x0112 (index 2, tag 1).
   - Writeback of 0x0010–0x0016 with 0xBEEF at 0x0012, then fill of 0x0110–0x0116.
   - Done at the end with CacheHit=0.
4. Rd 0x0003.
   - Err=1, Done=1 for one cycle; no mem_req; state unchanged.
   - Rd=Wr=1 gives the same result.
5. Memory acks each word 5 cycles after mem_req.
   - Stall held and mem_addr/mem_we stable between acks.
   - Done after 4×5+2 cycles.
6. Assert rst during WB word 2.
   - mem_req=0 and Stall=0 next cycle.
   - Rd 0x0010 then misses with a clean fill (no WB).
   - With DCACHE_STATS_EN: req_count/hit_count = 0 after reset; 3 requests with 1 hit give 3/1.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared types and geometry for the direct-mapped data cache controller.
package dcache_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WB       = 2'd1,
    FILL     = 2'd2,
    COMPLETE = 2'd3
  } state_t;

  localparam int unsigned WORDS_PER_LINE = 4;
  localparam int unsigned OFFSET_W       = 2;
  localparam int unsigned ADDR_W         = 16;
  localparam int unsigned WORD_W         = 16;

  // Byte-address bits left after the byte-select, word offset and index fields.
  function automatic int unsigned tag_width(input int unsigned index_w);
    return ADDR_W - index_w - OFFSET_W - 1;
  endfunction

endpackage

// File: rtl/dcache_array.sv
// Tag/valid/dirty/data storage: one combinational read port, one synchronous write port.
module dcache_array
  import dcache_pkg::*;
#(
  parameter int unsigned INDEX_W = 5,
  parameter int unsigned TAG_W   = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [INDEX_W-1:0]  rd_index,
  input  logic [OFFSET_W-1:0] rd_offset,
  output logic [TAG_W-1:0]    rd_tag,
  output logic                rd_valid,
  output logic                rd_dirty,
  output logic [WORD_W-1:0]   rd_word,
  input  logic [INDEX_W-1:0]  wr_index,
  input  logic [OFFSET_W-1:0] wr_offset,
  input  logic                word_we,
  input  logic [WORD_W-1:0]   wr_word,
  input  logic                dirty_set,
  input  logic                meta_we,
  input  logic [TAG_W-1:0]    meta_tag
);

  localparam int unsigned LINES = 2 ** INDEX_W;

  logic [WORD_W-1:0] data_q [LINES*WORDS_PER_LINE];
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [LINES-1:0]  valid_q;
  logic [LINES-1:0]  dirty_q;

  assign rd_word  = data_q[{rd_index, rd_offset}];
  assign rd_tag   = tag_q[rd_index];
  assign rd_valid = valid_q[rd_index];
  assign rd_dirty = dirty_q[rd_index];

  always_ff @(posedge clk) begin
    if (word_we) data_q[{wr_index, wr_offset}] <= wr_word;
    if (meta_we) tag_q[wr_index] <= meta_tag;
  end

  // Installing a line always leaves it clean; a later store sets dirty.
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (meta_we) begin
      valid_q[wr_index] <= 1'b1;
      dirty_q[wr_index] <= 1'b0;
    end else if (dirty_set) begin
      dirty_q[wr_index] <= 1'b1;
    end
  end

endmodule

// File: rtl/dcache_ctrl.sv
// Blocking direct-mapped write-back/write-allocate data cache controller.
// Optional statistics counters enabled by defining DCACHE_STATS_EN.
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int unsigned INDEX_W = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] Addr,
  input  logic [15:0] DataIn,
  input  logic        Rd,
  input  logic        Wr,
  output logic [15:0] DataOut,
  output logic        Done,
  output logic        Stall,
  output logic        CacheHit,
  output logic        Err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack,
  output logic [15:0] req_count,
  output logic [15:0] hit_count
);

  localparam int unsigned TAG_W = tag_width(INDEX_W);

  state_t state_q, state_d;
  logic [OFFSET_W-1:0] k_q, k_d;
  logic [15:1] q_addr;
  logic [15:0] q_data;
  logic        q_rd, q_wr;
  logic        latch;

  logic [OFFSET_W-1:0] a_offset, q_offset;
  logic [INDEX_W-1:0]  a_index, q_index;
  logic [TAG_W-1:0]    a_tag, q_tag;

  assign a_offset = Addr[2:1];
  assign a_index  = Addr[2+INDEX_W:3];
  assign a_tag    = Addr[15:3+INDEX_W];
  assign q_offset = q_addr[2:1];
  assign q_index  = q_addr[2+INDEX_W:3];
  assign q_tag    = q_addr[15:3+INDEX_W];

  logic [INDEX_W-1:0]  rd_index, wr_index;
  logic [OFFSET_W-1:0] rd_offset, wr_offset;
  logic [TAG_W-1:0]    rd_tag, meta_tag;
  logic                rd_valid, rd_dirty;
  logic [WORD_W-1:0]   rd_word, wr_word;
  logic                word_we, dirty_set, meta_we;

  logic is_req, is_err, is_hit;

  assign is_req = Rd | Wr;
  assign is_err = Addr[0] | (Rd & Wr);
  assign is_hit = rd_valid && (rd_tag == a_tag);

  dcache_array #(
    .INDEX_W(INDEX_W),
    .TAG_W  (TAG_W)
  ) u_array (
    .clk      (clk),
    .rst      (rst),
    .rd_index (rd_index),
    .rd_offset(rd_offset),
    .rd_tag   (rd_tag),
    .rd_valid (rd_valid),
    .rd_dirty (rd_dirty),
    .rd_word  (rd_word),
    .wr_index (wr_index),
    .wr_offset(wr_offset),
    .word_we  (word_we),
    .wr_word  (wr_word),
    .dirty_set(dirty_set),
    .meta_we  (meta_we),
    .meta_tag (meta_tag)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      q_addr  <= '0;
      q_data  <= '0;
      q_rd    <= 1'b0;
      q_wr    <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      if (latch) begin
        q_addr <= Addr[15:1];
        q_data <= DataIn;
        q_rd   <= Rd;
        q_wr   <= Wr;
      end
    end
  end

  // The single read port serves the lookup in IDLE and the latched line otherwise.
  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    latch     = 1'b0;
    DataOut   = '0;
    Done      = 1'b0;
    Stall     = 1'b0;
    CacheHit  = 1'b0;
    Err       = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    rd_index  = a_index;
    rd_offset = a_offset;
    wr_index  = q_index;
    wr_offset = k_q;
    wr_word   = mem_rdata;
    word_we   = 1'b0;
    dirty_set = 1'b0;
    meta_we   = 1'b0;
    meta_tag  = q_tag;
    unique case (state_q)
      IDLE: begin
        if (is_req) begin
          if (is_err) begin
            Err  = 1'b1;
            Done = 1'b1;
          end else if (is_hit) begin
            Done     = 1'b1;
            CacheHit = 1'b1;
            if (Rd) DataOut = rd_word;
            if (Wr) begin
              wr_index  = a_index;
              wr_offset = a_offset;
              wr_word   = DataIn;
              word_we   = 1'b1;
              dirty_set = 1'b1;
            end
          end else begin
            Stall   = 1'b1;
            latch   = 1'b1;
            k_d     = '0;
            state_d = (rd_valid && rd_dirty) ? WB : FILL;
          end
        end
      end
      WB: begin
        rd_index  = q_index;
        rd_offset = k_q;
        Stall     = 1'b1;
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {rd_tag, q_index, k_q, 1'b0};
        mem_wdata = rd_word;
        if (mem_ack) begin
          k_d = k_q + 2'd1;
          if (k_q == 2'd3) state_d = FILL;
        end
      end
      FILL: begin
        rd_index = q_index;
        Stall    = 1'b1;
        mem_req  = 1'b1;
        mem_addr = {q_tag, q_index, k_q, 1'b0};
        if (mem_ack) begin
          word_we = 1'b1;
          k_d     = k_q + 2'd1;
          if (k_q == 2'd3) begin
            meta_we = 1'b1;
            state_d = COMPLETE;
          end
        end
      end
      COMPLETE: begin
        rd_index  = q_index;
        rd_offset = q_offset;
        Done      = 1'b1;
        if (q_rd) DataOut = rd_word;
        if (q_wr) begin
          wr_offset = q_offset;
          wr_word   = q_data;
          word_we   = 1'b1;
          dirty_set = 1'b1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef DCACHE_STATS_EN
  logic [15:0] req_q, hit_q;
  logic        count_req, count_hit;

  assign count_req = (state_q == IDLE) && is_req && !is_err;
  assign count_hit = count_req && is_hit;

  always_ff @(posedge clk) begin
    if (!rst) begin
      req_q <= '0;
      hit_q <= '0;
    end else begin
      if (count_req && (req_q != '1)) req_q <= req_q + 16'd1;
      if (count_hit && (hit_q != '1)) hit_q <= hit_q + 16'd1;
    end
  end

  assign req_count = req_q;
  assign hit_count = hit_q;
`else
  assign req_count = '0;
  assign hit_count = '0;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed self-checking bench for dcache_ctrl with a word-wide handshaked memory model.
module tb_dcache_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] Addr, DataIn, DataOut;
  logic        Rd, Wr, Done, Stall, CacheHit, Err;
  logic        mem_req, mem_we, mem_ack;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic [15:0] req_count, hit_count;

  int passed = 0;
  int total  = 0;
  int unsigned lat = 1;

  logic [15:0] mem [0:32767];
  logic [15:0] log_addr [$];
  logic        log_we   [$];
  logic [15:0] log_data [$];

  dcache_ctrl #(.INDEX_W(5)) dut (
    .clk      (clk),
    .rst      (rst),
    .Addr     (Addr),
    .DataIn   (DataIn),
    .Rd       (Rd),
    .Wr       (Wr),
    .DataOut  (DataOut),
    .Done     (Done),
    .Stall    (Stall),
    .CacheHit (CacheHit),
    .Err      (Err),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ack  (mem_ack),
    .req_count(req_count),
    .hit_count(hit_count)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] pat(input logic [15:0] a);
    return a ^ 16'hA5A5;
  endfunction

  // Memory responder: acks after 'lat' cycles of mem_req, logging every transfer.
  initial begin
    int unsigned cnt;
    cnt       = 0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_req && rst) begin
        cnt++;
        if (cnt >= lat) begin
          mem_ack = 1'b1;
          if (mem_we) mem[mem_addr[15:1]] = mem_wdata;
          mem_rdata = mem[mem_addr[15:1]];
          log_addr.push_back(mem_addr);
          log_we.push_back(mem_we);
          log_data.push_back(mem_we ? mem_wdata : mem_rdata);
          cnt = 0;
        end else begin
          mem_ack = 1'b0;
        end
      end else begin
        mem_ack = 1'b0;
        cnt     = 0;
      end
    end
  end

  task automatic do_req(input logic [15:0] a, input logic [15:0] d, input logic r, input logic w,
                        output int cyc, output logic [15:0] dout, output logic hit,
                        output logic err, output logic stall0, output int gaps, output int unstable);
    logic        pr_req, pr_ack, pr_we;
    logic [15:0] pr_addr, pr_wdata;
    @(negedge clk);
    Addr = a; DataIn = d; Rd = r; Wr = w;
    #1;
    cyc = 1; stall0 = Stall; gaps = 0; unstable = 0;
    pr_req = mem_req; pr_ack = mem_ack; pr_we = mem_we; pr_addr = mem_addr; pr_wdata = mem_wdata;
    while (!Done && cyc < 400) begin
      if (!Stall) gaps++;
      @(negedge clk); #1;
      cyc++;
      if (pr_req && !pr_ack && mem_req &&
          ({mem_we, mem_addr, mem_wdata} !== {pr_we, pr_addr, pr_wdata})) unstable++;
      pr_req = mem_req; pr_ack = mem_ack; pr_we = mem_we; pr_addr = mem_addr; pr_wdata = mem_wdata;
    end
    dout = DataOut; hit = CacheHit; err = Err;
    if (!Done) begin
      total++;
      $display("FAIL req_timeout: addr %h got no Done after %0d cycles, required Done", a, cyc);
    end
    @(negedge clk);
    Rd = 1'b0; Wr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; Rd = 1'b0; Wr = 1'b0; Addr = '0; DataIn = '0;
    repeat (3) @(negedge clk);
    #1;
    total++;
    if ({Done, Stall, CacheHit, Err, mem_req, DataOut} !== 21'd0)
      $display("FAIL reset_outputs: got %h, required 0", {Done, Stall, CacheHit, Err, mem_req, DataOut});
    else passed++;
    total++;
    if ({req_count, hit_count} !== 32'd0)
      $display("FAIL reset_counters: got %h, required 0", {req_count, hit_count});
    else passed++;
    rst = 1'b1;
  endtask

  task automatic test_cold_miss();
    int cyc, gaps, uns, n0, bad;
    logic [15:0] dout; logic hit, err, st0;
    n0 = log_addr.size();
    do_req(16'h0010, 16'h0, 1'b1, 1'b0, cyc, dout, hit, err, st0, gaps, uns);
    total++;
    if (st0 !== 1'b1) $display("FAIL cold_stall: got %b, required 1", st0); else passed++;
    total++;
    if (cyc != 6) $display("FAIL cold_latency: got %0d, required 6", cyc); else passed++;
    total++;
    if ({hit, dout} !== {1'b0, 16'h1234})
      $display("FAIL cold_data: got hit=%b data=%h, required hit=0 data=1234", hit, dout);
    else passed++;
    bad = (log_addr.size() - n0 != 4) ? 1 : 0;
    for (int i = 0; i < 4 && bad == 0; i++)
      if (log_addr[n0+i] !== 16'h0010 + 16'(2*i) || log_we[n0+i] !== 1'b0) bad++;
    total++;
    if (bad != 0) $display("FAIL cold_fill_seq: got %0d transfers/bad, required reads 0010..0016", log_addr.size() - n0);
    else passed++;
    total++;
    if (gaps != 0) $display("FAIL cold_stall_gap: got %0d unstalled cycles, required 0", gaps); else passed++;
  endtask

  task automatic test_hit();
    int cyc, gaps, uns, n0;
    logic [15:0] dout; logic hit, err, st0;
    n0 = log_addr.size();
    do_req(16'h0014, 16'h0, 1'b1, 1'b0, cyc, dout, hit, err, st0, gaps, uns);
    total++;
    if ({cyc == 1, hit, st0} !== 3'b110)
      $display("FAIL hit_timing: got cyc=%0d hit=%b stall=%b, required cyc=1 hit=1 stall=0", cyc, hit, st0);
    else passed++;
    total++;
    if (dout !== pat(16'h0014)) $display("FAIL hit_data: got %h, required %h", dout, pat(16'h0014)); else passed++;
    total++;
    if (log_addr.size() != n0) $display("FAIL hit_no_mem: got %0d transfers, required 0", log_addr.size() - n0);
    else passed++;
  endtask

  task automatic test_writeback();
    int cyc, gaps, uns, n0, bad;
    logic [15:0] dout; logic hit, err, st0;
    logic [15:0] exp_a [8];
    logic [15:0] exp_d [8];
    exp_a = '{16'h0010, 16'h0012, 16'h0014, 16'h0016, 16'h0110, 16'h0112, 16'h0114, 16'h0116};
    exp_d = '{16'h1234, 16'hBEEF, pat(16'h0014), pat(16'h0016),
              pat(16'h0110), pat(16'h0112), pat(16'h0114), pat(16'h0116)};
    do_req(16'h0012, 16'hBEEF, 1'b0, 1'b1, cyc, dout, hit, err, st0, gaps, uns);
    total++;
    if ({cyc == 1, hit} !== 2'b11) $display("FAIL store_hit: got cyc=%0d hit=%b, required cyc=1 hit=1", cyc, hit);
    else passed++;
    n0 = log_addr.size();
    do_req(16'h0112, 16'h0, 1'b1, 1'b0, cyc, dout, hit, err, st0, gaps, uns);
    bad = (log_addr.size() - n0 != 8) ? 1 : 0;
    for (int i = 0; i < 8 && bad == 0; i++)
      if (log_addr[n0+i] !== exp_a[i] || log_we[n0+i] !== (i < 4) || log_data[n0+i] !== exp_d[i]) bad++;
    total++;
    if (bad != 0) $display("FAIL wb_fill_seq: got %0d transfers/bad, required WB 0010..0016 then fill 0110..0116", log_addr.size() - n0);
    else passed++;
    total++;
    if (cyc != 10) $display("FAIL wb_latency: got %0d, required 10", cyc); else passed++;
    total++;
    if ({hit, dout} !== {1'b0, pat(16'h0112)})
      $display("FAIL wb_data: got hit=%b data=%h, required hit=0 data=%h", hit, dout, pat(16'h0112));
    else passed++;
  endtask

  task automatic test_err();
    int cyc, gaps, uns, n0;
    logic [15:0] dout; logic hit, err, st0;
    n0 = log_addr.size();
    do_req(16'h0003, 16'h0, 1'b1, 1'b0, cyc, dout, hit, err, st0, gaps, uns);
    total++;
    if ({cyc == 1, err, hit} !== 3'b110)
      $display("FAIL err_odd: got cyc=%0d err=%b hit=%b, required cyc=1 err=1 hit=0", cyc, err, hit);
    else passed++;
    do_req(16'h0114, 16'h0, 1'b1, 1'b1, cyc, dout, hit, err, st0, gaps, uns);
    total++;
    if ({cyc == 1, err, hit} !== 3'b110)
      $display("FAIL err_rdwr: got cyc=%0d err=%b hit=%b, required cyc=1 err=1 hit=0", cyc, err, hit);
    else passed++;
    do_req(16'h0113, 16'h7777, 1'b0, 1'b1, cyc, dout, hit, err, st0, gaps, uns);
    total++;
    if (err !== 1'b1) $display("FAIL err_odd_store: got err=%b, required 1", err); else passed++;
    total++;
    if (log_addr.size() != n0) $display("FAIL err_no_mem: got %0d transfers, required 0", log_addr.size() - n0);
    else passed++;
    do_req(16'h0112, 16'h0, 1'b1, 1'b0, cyc, dout, hit, err, st0, gaps, uns);
    total++;
    if ({hit, dout} !== {1'b1, pat(16'h0112)})
      $display("FAIL err_unchanged: got hit=%b data=%h, required hit=1 data=%h", hit, dout, pat(16'h0112));
    else passed++;
  endtask

  task automatic test_slow_mem();
    int cyc, gaps, uns, n0;
    logic [15:0] dout; logic hit, err, st0;
    lat = 5;
    n0 = log_addr.size();
    do_req(16'h0210, 16'h0, 1'b1, 1'b0, cyc, dout, hit, err, st0, gaps, uns);
    lat = 1;
    total++;
    if (cyc != 22) $display("FAIL slow_latency: got %0d, required 22", cyc); else passed++;
    total++;
    if (gaps != 0) $display("FAIL slow_stall_gap: got %0d, required 0", gaps); else passed++;
    total++;
    if (uns != 0) $display("FAIL slow_mem_stable: got %0d changes, required 0", uns); else passed++;
    total++;
    if ({hit, dout, log_addr.size() - n0} !== {1'b0, pat(16'h0210), 32'd4})
      $display("FAIL slow_data: got hit=%b data=%h xfers=%0d, required hit=0 data=%h xfers=4",
               hit, dout, log_addr.size() - n0, pat(16'h0210));
    else passed++;
  endtask

  task automatic test_reset_mid();
    int cyc, gaps, uns, n0, wait_cyc;
    logic [15:0] dout; logic hit, err, st0;
    logic [15:0] exp_req, exp_hit;
    do_req(16'h0210, 16'h5555, 1'b0, 1'b1, cyc, dout, hit, err, st0, gaps, uns);
    @(negedge clk);
    Addr = 16'h0310; Rd = 1'b1; Wr = 1'b0;
    #1;
    wait_cyc = 0;
    while (!(mem_req && mem_we && mem_addr == 16'h0214) && wait_cyc < 50) begin
      @(negedge clk); #1;
      wait_cyc++;
    end
    total++;
    if (wait_cyc >= 50) $display("FAIL wb_word2_seen: got none in 50 cycles, required WB of 0214"); else passed++;
    rst = 1'b0; Rd = 1'b0;
    @(negedge clk); #1;
    total++;
    if ({mem_req, Stall, Done} !== 3'b000)
      $display("FAIL reset_mid: got req=%b stall=%b done=%b, required 000", mem_req, Stall, Done);
    else passed++;
    rst = 1'b1;
    total++;
    if ({req_count, hit_count} !== 32'd0)
      $display("FAIL reset_mid_counters: got %h, required 0", {req_count, hit_count});
    else passed++;
    n0 = log_addr.size();
    do_req(16'h0010, 16'h0, 1'b1, 1'b0, cyc, dout, hit, err, st0, gaps, uns);
    total++;
    if ({cyc == 6, log_addr.size() - n0 == 4, log_we[n0], log_addr[n0]} !== {1'b1, 1'b1, 1'b0, 16'h0010})
      $display("FAIL clean_refill: got cyc=%0d xfers=%0d, required cyc=6 and 4 reads from 0010", cyc, log_addr.size() - n0);
    else passed++;
    total++;
    if (dout !== 16'h1234) $display("FAIL clean_refill_data: got %h, required 1234", dout); else passed++;
    do_req(16'h0010, 16'h0, 1'b1, 1'b0, cyc, dout, hit, err, st0, gaps, uns);
    do_req(16'h0110, 16'h0, 1'b1, 1'b0, cyc, dout, hit, err, st0, gaps, uns);
`ifdef DCACHE_STATS_EN
    exp_req = 16'd3; exp_hit = 16'd1;
`else
    exp_req = 16'd0; exp_hit = 16'd0;
`endif
    total++;
    if ({req_count, hit_count} !== {exp_req, exp_hit})
      $display("FAIL stats: got req=%0d hit=%0d, required req=%0d hit=%0d", req_count, hit_count, exp_req, exp_hit);
    else passed++;
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) mem[i] = pat(16'(i * 2));
    mem[16'h0010 >> 1] = 16'h1234;
    test_reset();
    test_cold_miss();
    test_hit();
    test_writeback();
    test_err();
    test_slow_mem();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
